// File: rtl/disp_pkg.sv
// disp_pkg: shared state encoding, response codes and burst geometry helpers for the frame fetcher.
package disp_pkg;
   typedef enum logic [1:0] {IDLE, REQ, ADDR, DRAIN} state_t;
   localparam logic [1:0] OKAY = 2'b00;
   function automatic int bytes_per_burst(input int burst_len, input int data_w);
      return burst_len * data_w / 8;
   endfunction
   function automatic int bursts_per_line(input int h_pix, input int pix_bytes, input int burst_len, input int data_w);
      return h_pix * pix_bytes / bytes_per_burst(burst_len, data_w);
   endfunction
endpackage

// File: rtl/disp_fetch_addr.sv
// disp_fetch_addr: frame walk counters producing the next burst address and a last-burst-of-frame flag.
module disp_fetch_addr
   import disp_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 64,
   parameter int BURST_LEN = 16,
   parameter int H_PIX     = 640,
   parameter int V_LINE    = 480,
   parameter int PIX_BYTES = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              step,
   input  logic [ADDR_W-1:0] base,
   input  logic [15:0]       stride,
   output logic [ADDR_W-1:0] addr,
   output logic              last
);
   localparam int BB  = bytes_per_burst(BURST_LEN, DATA_W);
   localparam int BPL = bursts_per_line(H_PIX, PIX_BYTES, BURST_LEN, DATA_W);
   logic [ADDR_W-1:0] line_addr;
   logic [15:0]       stride_q, burst_cnt, line_cnt;
   logic              line_end;
   assign line_end = burst_cnt == 16'(BPL - 1);
   assign addr     = line_addr + ADDR_W'(burst_cnt) * ADDR_W'(BB);
   assign last     = line_end && line_cnt == 16'(V_LINE - 1);
   always_ff @(posedge clk) begin
      if (rst) begin
         line_addr <= '0;
         stride_q  <= '0;
         burst_cnt <= '0;
         line_cnt  <= '0;
      end else if (load) begin
         line_addr <= base;
         stride_q  <= stride;
         burst_cnt <= '0;
         line_cnt  <= '0;
      end else if (step) begin
         burst_cnt <= line_end ? '0 : burst_cnt + 16'd1;
         line_addr <= line_end ? line_addr + ADDR_W'(stride_q) : line_addr;
         line_cnt  <= line_end ? line_cnt + 16'd1 : line_cnt;
      end
   end
endmodule

// File: rtl/disp_fetch.sv
// disp_fetch: AXI read-burst frame fetch engine with outstanding-burst limit, abort/drain and error capture.
module disp_fetch
   import disp_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 64,
   parameter int BURST_LEN = 16,
   parameter int MAX_OUTST = 2,
   parameter int H_PIX     = 640,
   parameter int V_LINE    = 480,
   parameter int PIX_BYTES = 4
) (
   input  logic              ACLK,
   input  logic              ARST,
   input  logic              START,
   input  logic              DISPON,
   input  logic [ADDR_W-1:0] BASEADDR,
   input  logic [15:0]       STRIDE,
   input  logic              FIFOREADY,
   output logic [ADDR_W-1:0] ARADDR,
   output logic [7:0]        ARLEN,
   output logic              ARVALID,
   input  logic              ARREADY,
   input  logic              RVALID,
   input  logic              RLAST,
   input  logic [1:0]        RRESP,
   output logic              RREADY,
   output logic              BUSY,
   output logic              DONE,
   output logic              RERR
);
   state_t            state, state_n;
   logic              abort, abort_n, load, step, issue, done_n, last, ar_hs, r_last;
   logic [3:0]        outst, outst_n;
   logic [ADDR_W-1:0] addr;
   disp_fetch_addr #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN),
      .H_PIX(H_PIX), .V_LINE(V_LINE), .PIX_BYTES(PIX_BYTES)
   ) u_addr (
      .clk(ACLK), .rst(ARST), .load(load), .step(step),
      .base(BASEADDR), .stride(STRIDE), .addr(addr), .last(last)
   );
   assign ARLEN  = 8'(BURST_LEN - 1);
   assign BUSY   = state != IDLE;
   assign ar_hs  = ARVALID & ARREADY;
   assign r_last = RVALID & RREADY & RLAST;
   // Stray RLASTs after a reset must not wrap the counter below zero.
   assign outst_n = outst + {3'b0, ar_hs} - {3'b0, r_last && outst != 4'd0};
   always_comb begin
      state_n = state;
      abort_n = abort;
      load    = 1'b0;
      step    = 1'b0;
      issue   = 1'b0;
      done_n  = 1'b0;
      case (state)
         IDLE: begin
            load    = START & DISPON;
            abort_n = load ? 1'b0 : abort;
            state_n = load ? REQ : IDLE;
         end
         REQ: begin
            issue   = DISPON & FIFOREADY & (outst < 4'(MAX_OUTST));
            abort_n = ~DISPON;
            state_n = !DISPON ? DRAIN : issue ? ADDR : REQ;
         end
         ADDR: begin
            step    = ARREADY & ~last & DISPON;
            abort_n = ARREADY ? ~DISPON : abort;
            state_n = !ARREADY ? ADDR : (last || !DISPON) ? DRAIN : REQ;
         end
         DRAIN: begin
            done_n  = outst_n == 4'd0 && !abort;
            state_n = outst_n == 4'd0 ? IDLE : DRAIN;
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge ACLK) begin
      if (ARST) begin
         state   <= IDLE;
         abort   <= 1'b0;
         ARVALID <= 1'b0;
         ARADDR  <= '0;
         RREADY  <= 1'b0;
         DONE    <= 1'b0;
         RERR    <= 1'b0;
         outst   <= '0;
      end else begin
         state   <= state_n;
         abort   <= abort_n;
         ARVALID <= issue | (ARVALID & ~ARREADY);
         ARADDR  <= issue ? addr : ARADDR;
         RREADY  <= 1'b1;
         DONE    <= done_n;
         outst   <= outst_n;
         RERR    <= (RERR & ~load) | (RVALID & RREADY & (RRESP != OKAY));
      end
   end
endmodule

// File: tb/tb_disp_fetch.sv
// tb_disp_fetch: directed and randomized frame fetches checked against an address-list and burst-count model.
module tb_disp_fetch;
   logic        clk = 0, rst, start, dispon, fifoready, arready, rvalid, rlast;
   logic [31:0] baseaddr, araddr;
   logic [15:0] stride;
   logic [7:0]  arlen;
   logic [1:0]  rresp;
   logic        arvalid, rready, busy, done, rerr;
   int          n_cmp = 0, n_bad = 0;
   always #5 clk = ~clk;
   disp_fetch #(
      .ADDR_W(32), .DATA_W(64), .BURST_LEN(2), .MAX_OUTST(2),
      .H_PIX(8), .V_LINE(2), .PIX_BYTES(4)
   ) dut (
      .ACLK(clk), .ARST(rst), .START(start), .DISPON(dispon), .BASEADDR(baseaddr),
      .STRIDE(stride), .FIFOREADY(fifoready), .ARADDR(araddr), .ARLEN(arlen),
      .ARVALID(arvalid), .ARREADY(arready), .RVALID(rvalid), .RLAST(rlast),
      .RRESP(rresp), .RREADY(rready), .BUSY(busy), .DONE(done), .RERR(rerr)
   );
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic start_frame(input logic [31:0] b, input logic [15:0] s);
      baseaddr = b;
      stride   = s;
      dispon   = 1;
      start    = 1;
      step();
      start    = 0;
   endtask
   task automatic wait_arv();
      for (int i = 0; i < 10 && !arvalid; i++) step();
      chk("wait_arv", arvalid, 1);
   endtask
   task automatic send_burst();
      rvalid = 1;
      rlast  = 0;
      rresp  = 2'b00;
      step();
      rlast  = 1;
      step();
      rvalid = 0;
      rlast  = 0;
   endtask
   // Model: the frame is the list base + line*stride + burst*16 for 2 lines of 2 bursts.
   task automatic run_frame(input logic [31:0] b, input logic [15:0] s, input int ar_pct, input int r_pct, input int err_pct);
      logic [31:0] exp_q[$];
      logic [31:0] prev_a;
      int k = 0, pend = 0, beat = 0, dones = 0, first = -1;
      bit rerr_m = 0, prev_v = 0, prev_r = 0, hs, rv, rl, fin;
      for (int l = 0; l < 2; l++)
         for (int j = 0; j < 2; j++) exp_q.push_back(b + 32'(l) * {16'b0, s} + 32'(j * 16));
      fifoready = 1;
      arready   = 0;
      rvalid    = 0;
      start_frame(b, s);
      chk("rerr_clear", rerr, 0);
      for (int cyc = 1; cyc < 400; cyc++) begin
         if (prev_v && !prev_r) begin
            chk("ar_hold_v", arvalid, 1);
            chk("ar_hold_a", araddr, prev_a);
         end
         if (arvalid && first < 0) first = cyc;
         arready = $urandom_range(99) < ar_pct;
         hs = arvalid && arready;
         if (hs) begin
            chk("araddr", araddr, exp_q[k]);
            chk("outst_limit", pend < 2, 1);
         end
         rv     = pend > 0 && $urandom_range(99) < r_pct;
         rl     = rv && beat == 1;
         rvalid = rv;
         rlast  = rl;
         rresp  = (rv && $urandom_range(99) < err_pct) ? 2'b10 : 2'b00;
         if (rv) beat = beat == 1 ? 0 : beat + 1;
         rerr_m = rerr_m | (rresp != 2'b00);
         pend   = pend + int'(hs) - int'(rl);
         k      = k + int'(hs);
         fin    = k == 4 && pend == 0 && rl;
         prev_v = arvalid;
         prev_r = arready;
         prev_a = araddr;
         step();
         chk("done", done, fin);
         chk("outst", dut.outst, pend);
         chk("rerr", rerr, rerr_m);
         if (done) dones++;
         if (fin) begin
            chk("busy_end", busy, 0);
            break;
         end
      end
      rvalid  = 0;
      rlast   = 0;
      arready = 0;
      chk("first_ar_latency", first, 2);
      chk("bursts", k, 4);
      chk("done_count", dones, 1);
   endtask
   initial begin
      int hs_n;
      rst = 1; start = 0; dispon = 1; baseaddr = 0; stride = 0; fifoready = 1;
      arready = 0; rvalid = 0; rlast = 0; rresp = 0;
      step();
      step();
      chk("rst_arvalid", arvalid, 0);
      chk("rst_araddr", araddr, 0);
      chk("rst_rready", rready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rerr", rerr, 0);
      chk("rst_outst", dut.outst, 0);
      rst = 0;
      step();
      chk("rready", rready, 1);
      chk("arlen", arlen, 1);
      run_frame(32'h1000, 16'h100, 100, 100, 0);
      run_frame(32'h2000, 16'h40, 70, 60, 100);
      run_frame(32'h2400, 16'h80, 60, 50, 0);
      // Outstanding limit, then abort with two bursts in flight.
      start_frame(32'h1000, 16'h100);
      arready = 1;
      hs_n = 0;
      repeat (8) begin
         if (arvalid) hs_n++;
         step();
      end
      chk("lim_hs", hs_n, 2);
      chk("lim_arvalid", arvalid, 0);
      chk("lim_outst", dut.outst, 2);
      send_burst();
      chk("lim_arv_at_rlast", arvalid, 0);
      wait_arv();
      chk("lim_third_addr", araddr, 32'h1100);
      step();
      chk("lim_outst_again", dut.outst, 2);
      dispon = 0;
      repeat (3) begin
         step();
         chk("abort_no_ar", arvalid, 0);
         chk("abort_busy", busy, 1);
      end
      send_burst();
      chk("abort_no_done1", done, 0);
      send_burst();
      chk("abort_no_done2", done, 0);
      chk("abort_idle", busy, 0);
      start_frame(32'h1000, 16'h100);
      wait_arv();
      chk("restart_addr", araddr, 32'h1000);
      step();
      dispon = 0;
      send_burst();
      chk("restart_idle", busy, 0);
      // Backpressure on ARREADY and FIFOREADY.
      arready = 0;
      start_frame(32'h1000, 16'h100);
      wait_arv();
      chk("bp_addr0", araddr, 32'h1000);
      arready = 1;
      step();
      arready = 0;
      wait_arv();
      repeat (5) begin
         step();
         chk("bp_hold_v", arvalid, 1);
         chk("bp_hold_a", araddr, 32'h1010);
      end
      arready = 1;
      fifoready = 0;
      step();
      arready = 0;
      send_burst();
      send_burst();
      repeat (4) begin
         chk("bp_fifo_block", arvalid, 0);
         step();
      end
      dispon = 0;
      fifoready = 1;
      step();
      chk("bp_done0", done, 0);
      step();
      chk("bp_done1", done, 0);
      chk("bp_idle", busy, 0);
      // Reset while an address is pending.
      start_frame(32'h5000, 16'h100);
      wait_arv();
      rst = 1;
      step();
      chk("mid_rst_arvalid", arvalid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_outst", dut.outst, 0);
      chk("mid_rst_araddr", araddr, 0);
      rst = 0;
      rvalid = 1;
      rlast = 1;
      repeat (3) step();
      rvalid = 0;
      rlast = 0;
      chk("stray_outst", dut.outst, 0);
      chk("stray_busy", busy, 0);
      run_frame(32'hFFFF_FFE0, 16'h0040, 50, 50, 10);
      for (int i = 0; i < 4; i++)
         run_frame($urandom, 16'($urandom), 40 + i * 15, 30 + i * 15, 5);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/disp_fetch.md
Name: disp_fetch

Overview:
- Parametrised AXI read-burst frame fetch engine for the display pipeline. It is the successor to the fixed 640x480 / 16-beat display controller.
- On each frame start it walks a frame buffer line by line, with a programmable line stride, and issues fixed-length INCR read bursts.
- Flow control comes from the pixel FIFO level and a configurable outstanding-burst limit.
- Adds RRESP error capture, clean abort/drain when the display is switched off mid-frame, and a frame-done pulse.

Parameters:
- ADDR_W, 32, AXI address width.
- DATA_W, 64, AXI read data width; must be a power of 2, >= 32.
- BURST_LEN, 16, beats per burst (1..256); ARLEN = BURST_LEN-1.
- MAX_OUTST, 2, maximum bursts in flight (1..15).
- H_PIX, 640, pixels per line.
- V_LINE, 480, lines per frame.
- PIX_BYTES, 4, bytes per pixel in memory. H_PIX*PIX_BYTES must be a multiple of BURST_LEN*DATA_W/8.

Ports:
- ACLK  in  1  clock; all logic is on the rising edge.
- ARST  in  1  synchronous active-high reset.
- START  in  1  one-cycle frame-start pulse.
- DISPON  in  1  display enable; level signal.
- BASEADDR  in  ADDR_W  frame base address; sampled on accepted START.
- STRIDE  in  16  line pitch in bytes; sampled on accepted START.
- FIFOREADY  in  1  pixel FIFO has room for one more burst.
- ARADDR  out  ADDR_W  burst address.
- ARLEN  out  8  constant BURST_LEN-1.
- ARVALID  out  1  AR request valid.
- ARREADY  in  1  AR accept.
- RVALID  in  1  read data valid.
- RLAST  in  1  last beat of a burst.
- RRESP  in  2  read response.
- RREADY  out  1  read data accept.
- BUSY  out  1  frame fetch or drain in progress.
- DONE  out  1  one-cycle pulse when a full frame completes.
- RERR  out  1  sticky; set on any beat with RRESP != 0.

Behaviour:
- **Reset values:** ARVALID=0, ARADDR=0, RREADY=0, BUSY=0, DONE=0, RERR=0, outstanding=0, state=IDLE. From the first cycle after reset, RREADY=1 constantly; the FIFO is protected via FIFOREADY.
- **Derived constants:** BB = BURST_LEN*DATA_W/8 (bytes per burst); BPL = H_PIX*PIX_BYTES/BB (bursts per line).
- **State IDLE:** START&DISPON latches line_addr=BASEADDR, stride, burst_cnt=0, line_cnt=0, then goes to REQ. START while not IDLE is ignored. START with DISPON=0 is ignored.
- **State REQ:** when FIFOREADY=1, outstanding<MAX_OUTST and DISPON=1, assert ARVALID next cycle with ARADDR=line_addr+burst_cnt*BB, then go to ADDR.
- **State ADDR:** ARVALID and ARADDR are held stable until ARREADY, per AXI rules; ARVALID is never withdrawn. On the handshake, outstanding increments and ARVALID drops.
  - If this was not the last burst of the frame: advance counters. burst_cnt wraps at BPL; on wrap, line_addr += stride and line_cnt increments. Go to REQ.
  - If it was the last burst: go to DRAIN.
- **State DRAIN:** wait until outstanding==0.
  - Normal end: DONE pulses for one cycle on the cycle outstanding reaches 0, then IDLE.
  - After abort: go to IDLE with no DONE.
- **Abort:** DISPON low in REQ goes straight to DRAIN with the abort flag set. DISPON low in ADDR completes the pending handshake first, then goes to DRAIN with the abort flag set.
- **Outstanding counter:** +1 on ARVALID&ARREADY; -1 on RVALID&RREADY&RLAST. Both in the same cycle leaves it unchanged. It never exceeds MAX_OUTST.
- **Latency:** the first ARVALID appears 2 cycles after START when FIFOREADY=1.
- **BUSY** = (state != IDLE).
- **RERR** sets on RVALID&RREADY&(RRESP!=0). It is cleared only by ARST or by an accepted START.
- **Address arithmetic:** modulo 2^ADDR_W; wrap is silent. STRIDE smaller than the line size is legal (overlapping lines).
- **Reset mid-burst:** all state returns to reset values in the next cycle; in-flight R beats after reset are accepted and ignored, and the outstanding counter does not go negative (saturates at 0).

Decomposition:
- Package disp_pkg holds:
  - BB and BPL localparam-style constants (functions of the parameters);
  - the state enum (IDLE, REQ, ADDR, DRAIN);
  - the OKAY response constant 2'b00.
- One sub-module, disp_fetch_addr, holds the line_addr/burst_cnt/line_cnt counters, the ARADDR computation and the last-burst flag. It is driven by a step strobe and a load strobe.
- The top module keeps the FSM, outstanding counter, RERR and DONE.

Test Plan:
Bench parameters: H_PIX=8, V_LINE=2, BURST_LEN=2, DATA_W=64 (so BB=16, BPL=2).
- **Basic frame:** BASEADDR=0x1000, STRIDE=0x100, FIFOREADY=1, ARREADY=1, zero-latency slave -> ARADDR sequence 0x1000, 0x1010, 0x1100, 0x1110, ARLEN=1; DONE pulses once after the 4th RLAST; BUSY then falls.
- **Outstanding limit:** MAX_OUTST=2, slave withholds R data -> exactly 2 AR handshakes, then ARVALID stays 0 until the first RLAST; after it, the 3rd AR is issued.
- **Backpressure:** ARREADY low for 5 cycles -> ARVALID and ARADDR=0x1010 are held stable all 5 cycles. FIFOREADY=0 -> no new ARVALID rises.
- **Abort:** DISPON drops after the 2nd AR handshake -> no further AR; DRAIN until 2 RLASTs; no DONE pulse; BUSY falls; a later START with DISPON=1 restarts at BASEADDR.
- **Error and simultaneous events:** one beat with RRESP=2'b10 -> RERR=1, which stays set through DONE and clears on the next START. An AR handshake and RLAST in the same cycle leave outstanding unchanged.
- **Reset mid-frame:** ARST asserted for 1 cycle during ADDR -> the next cycle has ARVALID=0, BUSY=0, outstanding=0; stray RLAST beats afterwards cause no underflow.
